// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, frame constants and parity helper.
// Also used by the APB glue and the planned receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick pulses on the last cycle of each max(divisor,1)-cycle period.
// Kept generic so the receiver can drive it with an oversampling divisor.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] divisor,
  input  logic             clear,
  input  logic             enable,
  output logic             bit_tick
);

  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] last_cnt;

  // A zero divisor behaves as one, so the tick fires every enabled cycle.
  assign last_cnt = (divisor == '0) ? '0 : (divisor - ONE);
  assign bit_tick = enable && (cnt_q == last_cnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = bit_tick ? '0 : (cnt_q + ONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with a one-entry holding buffer for gapless back-to-back frames.
// Frame: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 stop2,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  tx_state_t            state_q, state_d;
  logic                 txd_q, txd_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 par_en_q, par_en_d;
  logic                 stop2_q, stop2_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;

  logic                 bit_tick;
  logic                 accept;
  logic                 frame_end;
  logic                 shifter_free;
  logic                 load;
  logic [DATA_BITS-1:0] load_data;

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .divisor  (div_q),
    .clear    (load),
    .enable   (state_q != IDLE),
    .bit_tick (bit_tick)
  );

  assign tx_ready     = !hold_full_q;
  assign accept       = tx_valid && tx_ready;
  assign frame_end    = (state_q == STOP) && bit_tick && (bit_cnt_q == {2'b00, stop2_q});
  assign shifter_free = (state_q == IDLE) || frame_end;
  // A held byte always wins the shifter over a byte arriving in the same cycle.
  assign load         = shifter_free && (hold_full_q || accept);
  assign load_data    = hold_full_q ? hold_q : tx_data;

  assign txd     = txd_q;
  assign tx_done = frame_end;
  assign tx_busy = (state_q != IDLE) || hold_full_q;

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (shifter_free && hold_full_q) begin
      hold_full_d = 1'b0;
    end
    if (accept && !shifter_free) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    txd_d     = txd_q;
    sh_d      = sh_q;
    par_d     = par_q;
    par_en_d  = par_en_q;
    stop2_d   = stop2_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    if (load) begin
      state_d   = START;
      txd_d     = 1'b0;
      sh_d      = load_data;
      par_d     = calc_parity(load_data, parity_odd);
      par_en_d  = parity_en;
      stop2_d   = stop2;
      div_d     = baud_div;
      bit_cnt_d = 3'd0;
    end else if (frame_end) begin
      state_d = IDLE;
      txd_d   = 1'b1;
    end else if (bit_tick) begin
      case (state_q)
        START: begin
          state_d   = DATA;
          txd_d     = sh_q[0];
          bit_cnt_d = 3'd0;
        end
        DATA: begin
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
            bit_cnt_d = 3'd0;
            if (par_en_q) begin
              state_d = PARITY;
              txd_d   = par_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            sh_d      = sh_q >> 1;
            txd_d     = sh_q[1];
          end
        end
        PARITY: begin
          state_d   = STOP;
          txd_d     = 1'b1;
          bit_cnt_d = 3'd0;
        end
        STOP: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        default: begin
          state_d = IDLE;
          txd_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      txd_q       <= 1'b1;
      sh_q        <= '0;
      par_q       <= 1'b0;
      par_en_q    <= 1'b0;
      stop2_q     <= 1'b0;
      div_q       <= '0;
      bit_cnt_q   <= 3'd0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      txd_q       <= txd_d;
      sh_q        <= sh_d;
      par_q       <= par_d;
      par_en_q    <= par_en_d;
      stop2_q     <= stop2_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: random and directed traffic against a per-cycle txd waveform model.
// The model expands each accepted byte into its frame bit sequence and tracks the holding buffer.
module tb_uart_tx;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [15:0] baud_div = 16'd4;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        stop2 = 1'b0;
  logic        txd;
  logic        tx_busy;
  logic        tx_done;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx #(.DIV_W(16)) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .txd        (txd),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected txd for each upcoming cycle, plus the holding buffer.
  bit       exp_q[$];
  bit       m_hold_full = 1'b0;
  bit [7:0] m_hold = 8'h00;
  bit       m_acc = 1'b0;
  bit       m_free;
  bit       m_take;

  task automatic start_frame(input bit [7:0] d, input int div, input bit pen, input bit podd,
                             input bit s2);
    bit bits[$];
    int per;
    per = (div == 0) ? 1 : div;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back((^d) ^ podd);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int c = 0; c < per; c++) exp_q.push_back(bits[i]);
    end
  endtask

  always begin
    @(posedge PCLK);
    m_acc = 1'b0;
    if (!PRESETn) begin
      exp_q.delete();
      m_hold_full = 1'b0;
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      m_free = (exp_q.size() == 0);
      m_take = tx_valid && !m_hold_full;
      m_acc  = m_take;
      if (m_take)
        $display("xfer data=0x%02h div=%0d par_en=%0b odd=%0b stop2=%0b t=%0t",
                 tx_data, baud_div, parity_en, parity_odd, stop2, $time);
      if (m_free && m_hold_full) begin
        start_frame(m_hold, int'(baud_div), parity_en, parity_odd, stop2);
        m_hold_full = 1'b0;
      end else if (m_free && m_take) begin
        start_frame(tx_data, int'(baud_div), parity_en, parity_odd, stop2);
        m_take = 1'b0;
      end
      if (m_take) begin
        m_hold      = tx_data;
        m_hold_full = 1'b1;
      end
    end
    #1;
    check("txd", txd, (exp_q.size() > 0) ? exp_q[0] : 1'b1);
    check("tx_done", tx_done, exp_q.size() == 1);
    check("tx_ready", tx_ready, !m_hold_full);
    check("tx_busy", tx_busy, (exp_q.size() > 0) || m_hold_full);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic send(input logic [7:0] d, input bit keep);
    int budget;
    budget = 2000;
    tx_data  = d;
    tx_valid = 1'b1;
    do begin
      @(negedge PCLK);
      budget--;
    end while (!m_acc && budget > 0);
    check("accept", m_acc, 1);
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 5000;
    while ((exp_q.size() > 0 || m_hold_full) && budget > 0) begin
      @(negedge PCLK);
      budget--;
    end
    check("idle_busy", tx_busy, 0);
  endtask

  task automatic set_cfg(input int div, input bit pen, input bit podd, input bit s2);
    baud_div   = 16'(div);
    parity_en  = pen;
    parity_odd = podd;
    stop2      = s2;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle(4);
    PRESETn = 1'b1;
    idle(100);

    set_cfg(4, 0, 0, 0);
    send(8'hA5, 0);
    wait_idle();
    idle(3);

    set_cfg(3, 1, 0, 0);
    send(8'hA5, 0);
    wait_idle();
    set_cfg(3, 1, 1, 0);
    send(8'hA5, 0);
    wait_idle();
    set_cfg(3, 1, 1, 1);
    send(8'hA5, 0);
    wait_idle();

    set_cfg(4, 0, 0, 0);
    send(8'h01, 1);
    send(8'h02, 1);
    send(8'h03, 0);
    wait_idle();

    set_cfg(0, 0, 0, 0);
    send(8'h6E, 0);
    wait_idle();
    set_cfg(0, 1, 1, 1);
    send(8'h81, 1);
    send(8'h7F, 0);
    wait_idle();

    set_cfg(4, 0, 0, 0);
    send(8'h3C, 0);
    idle(5);
    baud_div = 16'd8;
    send(8'hC3, 0);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      set_cfg($urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      send(8'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        tx_valid = 1'b0;
        idle($urandom_range(0, 20));
      end
    end
    tx_valid = 1'b0;
    wait_idle();

    set_cfg(4, 0, 0, 0);
    send(8'h5A, 0);
    send(8'h99, 0);
    idle(15);
    @(posedge PCLK);
    #2;
    PRESETn = 1'b0;
    #1;
    check("async_txd", txd, 1);
    check("async_ready", tx_ready, 1);
    check("async_busy", tx_busy, 0);
    idle(3);
    PRESETn = 1'b1;
    idle(80);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial transmitter directly downstream of the APB glue/register block. It accepts bytes through a valid/ready handshake from the glue's TX data register path and serialises them on txd as UART frames. Frame format is LSB first: start bit, 8 data bits, optional even/odd parity bit, then 1 or 2 stop bits. A one-entry holding buffer lets the glue load the next byte while the current one shifts out, so back-to-back frames have no idle gap.

Parameters:
DATA_BITS, 8, data bits per frame (fixed at 8 for this revision).
DIV_W, 16, width of the baud divisor.

Ports:
PCLK  in  1  system clock; the single clock of the block.
PRESETn  in  1  reset; asynchronous assert, active low.
tx_data  in  8  byte to transmit.
tx_valid  in  1  tx_data is valid.
tx_ready  out  1  block can accept a byte this cycle.
baud_div  in  DIV_W  PCLK cycles per bit; 0 is treated as 1.
parity_en  in  1  insert a parity bit.
parity_odd  in  1  1 = odd parity, 0 = even parity.
stop2  in  1  1 = two stop bits, 0 = one stop bit.
txd  out  1  serial output, registered; idles high.
tx_busy  out  1  a frame is shifting or the holding buffer is full.
tx_done  out  1  one-cycle pulse on the last cycle of a frame's final stop bit.

Behaviour:
- Reset (PRESETn low, asynchronous): state IDLE, txd=1, tx_ready=1, tx_busy=0, tx_done=0. Holding buffer empty; baud counter 0; bit counter 0.
- Handshake:
  - Transfer occurs on a rising PCLK edge with tx_valid && tx_ready.
  - tx_ready = !hold_full.
  - tx_data is not sampled without tx_ready.
  - tx_valid may drop at any time without penalty.
- Byte routing on transfer:
  - If the shifter is free (IDLE, or the last cycle of the final stop bit), the byte goes straight into the shifter.
  - Otherwise it goes into the holding buffer.
- Shifter load:
  - Loads from the holding buffer whenever the shifter becomes free.
  - The holding buffer takes priority over a same-cycle new transfer. The new byte then goes into the holding buffer, which was just emptied.
- Config latch: baud_div, parity_en, parity_odd and stop2 are latched when the shifter loads. Changes during a frame do not affect that frame.
- Latency: txd goes low on the edge of the transfer (direct load). The first data bit starts exactly baud_div cycles later.
- States and transitions:
  - IDLE -> START on load.
  - START -> DATA after one bit period.
  - DATA shifts 8 bits, LSB first, then goes to PARITY if parity_en, else STOP.
  - PARITY -> STOP.
  - STOP lasts 1 or 2 bit periods.
  - On leaving STOP, go to START if a byte is available (holding buffer or same-cycle transfer), else IDLE.
- Parity bit = XOR of the 8 data bits, XOR parity_odd.
- Baud counter:
  - Counts 0..max(baud_div,1)-1 and wraps.
  - Its terminal count advances the bit, so each bit lasts exactly max(baud_div,1) PCLK cycles.
  - Clears to 0 on load.
- Frame length = (10 + parity_en + stop2) bit periods.
- Status outputs:
  - tx_done is asserted in the final cycle of the last stop bit, even if a new frame follows immediately.
  - tx_busy = (state != IDLE) || hold_full; it is combinational from registers.
- Reset mid-frame: txd returns high immediately; the frame and the held byte are discarded.

Decomposition:
- uart_pkg (shared with the glue and the future RX block) contains:
  - tx_state_t enum {IDLE, START, DATA, PARITY, STOP};
  - DATA_BITS constant;
  - a parity function.
- One sub-module: uart_baud_gen.
  - Inputs: divisor, clear, enable.
  - Output: a one-cycle bit_tick pulse.
  - The future uart_rx will reuse it with oversampling.

Test Plan:
- Reset/idle: hold PRESETn low, then release -> txd=1, tx_ready=1, tx_busy=0, tx_done=0; no toggling for 100 cycles with tx_valid=0.
- Single byte: baud_div=4, 8N1, send 0xA5 -> txd for 4 cycles each: 0,1,0,1,0,0,1,0,1,1; tx_done pulse at cycle 40 after transfer; tx_busy low after it.
- Parity and stop: baud_div=3, parity_en=1.
  - 0xA5 even -> parity bit 0; odd -> 1.
  - stop2=1 -> frame is 36 cycles with two high stop bits.
- Back-to-back: three bytes 0x01, 0x02, 0x03 with tx_valid held.
  - Second byte accepted at once; tx_ready=0 until the first frame ends.
  - No idle gap between frames; three tx_done pulses 40 cycles apart (baud_div=4).
- Boundary: baud_div=0 -> each bit lasts 1 cycle. Changing baud_div mid-frame from 4 to 8 -> current frame stays at 4, next frame uses 8.
- Reset mid-frame: assert PRESETn during DATA with a byte held -> txd=1 asynchronously. After release: IDLE, holding buffer empty, no further frames.
